cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_seq_pkg.sv | 24 ++
 rtl/cpu_sequencer_sat_counter.sv | 23 ++
 rtl/cpu_sequencer.sv | 127 ++++++++++++
 tb/tb_cpu_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types for the CPU phase sequencer: 4-bit phase encoding and small helpers.
// Consumers: cpu_sequencer (top) and its testbench-independent sub-modules.
package cpu_seq_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_MEM    = 4'd3,
        ST_WB     = 4'd4,
        ST_HALT   = 4'd5,
        ST_JFETCH = 4'd9,
        ST_BOOT0  = 4'd14,
        ST_BOOT1  = 4'd15
    } seq_state_t;

    localparam logic [3:0] EXEC_CNT_MAX = 4'd15;

    // Phases that talk to memory and therefore honour wait_request.
    function automatic logic is_mem_phase(input seq_state_t s);
        return (s == ST_FETCH) || (s == ST_JFETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/cpu_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else if (inc && (q_q != {W{1'b1}})) begin
            q_q <= q_q + W'(1);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/cpu_sequencer.sv
// CPU phase sequencer: boot, fetch/decode/exec/mem/wb loop, jump fetch and halt.
// Optional performance counters (cycle_count, stall_count) under `SEQ_PERF_CNT_EN.
//
// state  | meaning
// BOOT1  | first cycle out of reset
// BOOT0  | second boot cycle
// FETCH  | instruction fetch, waits on memory, decides jump
// JFETCH | fetch from jump target, waits on memory
// DECODE | decode
// EXEC   | execute, min EXEC_CYCLES long, extended by exec_busy
// MEM    | memory access, waits on memory
// WB     | writeback, decides halt
// HALT   | stopped until reset
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wait_request,
    input  logic             exec_busy,
    input  logic             jump,
    input  logic             halt,
    output logic [3:0]       state,
    output logic             active,
    output logic [3:0]       exec_cnt,
    output logic             retire
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count
`endif
);

    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 16 || CNT_W < 1) begin : g_bad_param
        $error("cpu_sequencer: EXEC_CYCLES must be 1..16 and CNT_W >= 1");
    end

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    seq_state_t state_q, state_d;
    logic       active_q;
    logic [3:0] exec_cnt_q;
    logic       retire_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT1:  state_d = ST_BOOT0;
            ST_BOOT0:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (!wait_request) begin
                    state_d = jump ? ST_JFETCH : ST_DECODE;
                end
            end
            ST_JFETCH: begin
                if (!wait_request) begin
                    state_d = ST_EXEC;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if ((exec_cnt_q >= EXEC_LAST) && !exec_busy) begin
                    state_d = ST_MEM;
                end
            end
            ST_MEM: begin
                if (!wait_request) begin
                    state_d = ST_WB;
                end
            end
            ST_WB:     state_d = halt ? ST_HALT : ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_BOOT1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_BOOT1;
            active_q   <= 1'b1;
            exec_cnt_q <= '0;
            retire_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_q && (state_d != ST_HALT);
            retire_q <= (state_q == ST_WB);
            // Counter restarts on entry and otherwise keeps the last instruction's value.
            if (state_d == ST_EXEC) begin
                if (state_q != ST_EXEC) begin
                    exec_cnt_q <= '0;
                end else if (exec_cnt_q != EXEC_CNT_MAX) begin
                    exec_cnt_q <= exec_cnt_q + 4'd1;
                end
            end
        end
    end

    assign state    = state_q;
    assign active   = active_q;
    assign exec_cnt = exec_cnt_q;
    assign retire   = retire_q;

`ifdef SEQ_PERF_CNT_EN
    logic stall_hit;

    assign stall_hit = (is_mem_phase(state_q) && wait_request) ||
                       ((state_q == ST_EXEC) && exec_busy);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .clr (!reset),
        .inc (active_q),
        .q   (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (!reset),
        .inc (stall_hit),
        .q   (stall_count)
    );
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed literal checks plus randomized run vs a model.
module tb_cpu_sequencer;

    localparam int EXEC_CYC = 3;
    localparam int CW       = 8;
    localparam int CMAX     = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset, wait_request, exec_busy, jump, halt;
    logic [3:0] state;
    logic active;
    logic [3:0] exec_cnt;
    logic retire;
`ifdef SEQ_PERF_CNT_EN
    logic [CW-1:0] cycle_count, stall_count;
`endif

    always #5 clk = ~clk;

    cpu_sequencer #(.EXEC_CYCLES(EXEC_CYC), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .wait_request (wait_request),
        .exec_busy    (exec_busy),
        .jump         (jump),
        .halt         (halt),
        .state        (state),
        .active       (active),
        .exec_cnt     (exec_cnt),
        .retire       (retire)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_count  (cycle_count),
        .stall_count  (stall_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Reference model: phases as plain numbers, successor table plus hold rules.
    int m_state  = 15;
    bit m_active = 1;
    int m_cnt    = 0;
    bit m_retire = 0;
    int m_cyc    = 0;
    int m_stall  = 0;
    int succ [16];

    initial begin
        for (int i = 0; i < 16; i++) succ[i] = 15;
        succ[15] = 14; succ[14] = 0; succ[9] = 2; succ[1] = 2;
        succ[2] = 3;   succ[3] = 4;  succ[5] = 5;
    end

    task automatic model_step();
        int  nxt;
        bit  held;
        if (!reset) begin
            m_state = 15; m_active = 1; m_cnt = 0; m_retire = 0; m_cyc = 0; m_stall = 0;
            return;
        end
        held = 0;
        if (m_state == 0)      nxt = jump ? 9 : 1;
        else if (m_state == 4) nxt = halt ? 5 : 0;
        else                   nxt = succ[m_state];
        if ((m_state == 0 || m_state == 9 || m_state == 3) && wait_request) begin
            nxt = m_state; held = 1;
        end
        if (m_state == 2 && exec_busy) begin
            nxt = 2; held = 1;
        end
        if (m_state == 2 && m_cnt + 1 < EXEC_CYC) nxt = 2;
        if (m_active && m_cyc < CMAX) m_cyc++;
        if (held && m_stall < CMAX) m_stall++;
        if (nxt == 2) m_cnt = (m_state == 2) ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
        m_retire = (m_state == 4);
        m_active = m_active && (nxt != 5);
        m_state  = nxt;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_state", int'(state), m_state);
            chk("m_active", int'(active), int'(m_active));
            chk("m_retire", int'(retire), int'(m_retire));
            if (m_state == 2) chk("m_exec_cnt", int'(exec_cnt), m_cnt);
`ifdef SEQ_PERF_CNT_EN
            chk("m_cycle_count", int'(cycle_count), m_cyc);
            chk("m_stall_count", int'(stall_count), m_stall);
`endif
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic goto_state(input int target);
        int n;
        n = 0;
        while (m_state != target && n < 60) begin
            next_cycle();
            n++;
        end
        if (m_state != target) chk("goto_timeout", m_state, target);
    endtask

    task automatic quiet();
        wait_request = 0; exec_busy = 0; jump = 0; halt = 0; reset = 1;
    endtask

    int lit_state [12] = '{14, 0, 1, 2, 2, 2, 3, 4, 0, 1, 2, 2};
    int lit_ret   [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int lit_cnt   [12] = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1};

    initial begin
        reset = 0; wait_request = 0; exec_busy = 0; jump = 0; halt = 0;
        next_cycle();
        next_cycle();
        chk("rst_state", int'(state), 15);
        chk("rst_active", int'(active), 1);
        chk("rst_exec_cnt", int'(exec_cnt), 0);
        chk("rst_retire", int'(retire), 0);
`ifdef SEQ_PERF_CNT_EN
        chk("rst_cycle_count", int'(cycle_count), 0);
        chk("rst_stall_count", int'(stall_count), 0);
`endif
        chk_en = 1;
        reset = 1;

        for (int i = 0; i < 12; i++) begin
            next_cycle();
            chk("boot_seq_state", int'(state), lit_state[i]);
            chk("boot_seq_retire", int'(retire), lit_ret[i]);
            if (lit_state[i] == 2) chk("boot_seq_exec_cnt", int'(exec_cnt), lit_cnt[i]);
        end

        goto_state(0);
        jump = 1;
        next_cycle();
        jump = 0;
        chk("jump_jfetch", int'(state), 9);
        next_cycle();
        chk("jump_exec", int'(state), 2);

        goto_state(3);
        wait_request = 1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            chk("mem_wait_hold", int'(state), 3);
        end
        wait_request = 0;
        next_cycle();
        chk("mem_wait_wb", int'(state), 4);

        goto_state(2);
        exec_busy = 1;
        repeat (20) next_cycle();
        chk("exec_cnt_sat", int'(exec_cnt), 15);
        chk("exec_busy_hold", int'(state), 2);
        exec_busy = 0;
        next_cycle();
        chk("exec_sat_exit", int'(state), 3);

        goto_state(4);
        halt = 1;
        next_cycle();
        halt = 0;
        chk("halt_state", int'(state), 5);
        chk("halt_active", int'(active), 0);
        chk("halt_retire", int'(retire), 1);
        wait_request = 1; jump = 1; exec_busy = 1;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            chk("halt_hold", int'(state), 5);
            chk("halt_active_hold", int'(active), 0);
        end
        reset = 0;
        next_cycle();
        quiet();
        chk("halt_reset_state", int'(state), 15);
        chk("halt_reset_active", int'(active), 1);

        goto_state(2);
        exec_busy = 1;
        next_cycle();
        reset = 0;
        next_cycle();
        quiet();
        chk("exec_reset_state", int'(state), 15);
        chk("exec_reset_cnt", int'(exec_cnt), 0);
        chk("exec_reset_retire", int'(retire), 0);

        for (int i = 0; i < 400; i++) begin
            wait_request = ($urandom % 4) == 0;
            exec_busy    = ($urandom % 3) == 0;
            jump         = ($urandom % 3) == 0;
            halt         = 0;
            next_cycle();
        end
        for (int i = 0; i < 1500; i++) begin
            wait_request = ($urandom % 4) == 0;
            exec_busy    = ($urandom % 3) == 0;
            jump         = ($urandom % 3) == 0;
            halt         = ($urandom % 8) == 0;
            reset        = ($urandom % 50) != 0;
            next_cycle();
        end
        quiet();
        next_cycle();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
